monostable_pulse_meter: RTL and testbench



---
 rtl/monostable_pulse_meter.sv | 123 ++++++++++++
 tb/tb_monostable_pulse_meter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/monostable_pulse_meter.sv
// Resynchronises the one-shot Q output and measures each pulse width in clk cycles; the result
// appears SyncStages+1 edges after q_in falls, held in one register; a result arriving while it is full is dropped (sticky overrun).
module monostable_pulse_meter #(
    parameter int CountWidth = 16,
    parameter int MinWidth   = 80,
    parameter int MaxWidth   = 120,
    parameter int SyncStages = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  q_in,
    output logic                  meas_valid,
    input  logic                  meas_ready,
    output logic [CountWidth-1:0] meas_width,
    output logic                  meas_short,
    output logic                  meas_long,
    output logic                  meas_sat,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic [1:0] {ARM, IDLE, COUNT} state_t;

    localparam logic [CountWidth-1:0] MIN_W   = CountWidth'(MinWidth);
    localparam logic [CountWidth-1:0] MAX_W   = CountWidth'(MaxWidth);
    localparam logic [CountWidth-1:0] CNT_MAX = '1;

    state_t                  state_q, state_d;
    logic [SyncStages-1:0]   sync_q, sync_d;
    logic                    q_p_q, q_p_d;
    logic [CountWidth-1:0]   count_q, count_d;
    logic                    sat_q, sat_d;
    logic                    vld_q, vld_d;
    logic [CountWidth-1:0]   width_q, width_d;
    logic                    short_q, short_d;
    logic                    long_q, long_d;
    logic                    rsat_q, rsat_d;
    logic                    ovr_q, ovr_d;
    logic                    q_s, rise, fall, capture, xfer, load;

    always_comb begin
        sync_d  = {sync_q[SyncStages-2:0], q_in};
        q_s     = sync_q[SyncStages-1];
        q_p_d   = q_s;
        rise    = q_s & ~q_p_q;
        fall    = ~q_s & q_p_q;
        state_d = state_q;
        count_d = count_q;
        sat_d   = sat_q;
        capture = 1'b0;
        case (state_q)
            ARM:  if (!q_s) state_d = IDLE;
            IDLE: if (rise) begin
                state_d = COUNT;
                count_d = CountWidth'(1);
                sat_d   = 1'b0;
            end
            COUNT: if (q_s) begin
                // Pin at all-ones once the count would overflow.
                if (count_q == CNT_MAX) sat_d = 1'b1;
                else                    count_d = count_q + CountWidth'(1);
            end else if (fall) begin
                capture = 1'b1;
                state_d = IDLE;
            end
            default: state_d = ARM;
        endcase

        xfer    = vld_q & meas_ready;
        load    = capture & (~vld_q | meas_ready);
        vld_d   = vld_q;
        width_d = width_q;
        short_d = short_q;
        long_d  = long_q;
        rsat_d  = rsat_q;
        ovr_d   = ovr_q | (capture & ~load);
        if (load) begin
            vld_d   = 1'b1;
            width_d = count_q;
            short_d = count_q < MIN_W;
            long_d  = (count_q > MAX_W) | sat_q;
            rsat_d  = sat_q;
        end else if (xfer) begin
            vld_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // The synchroniser keeps running through reset so ARM sees the true line level.
        sync_q <= sync_d;
        q_p_q  <= q_p_d;
        if (reset) begin
            state_q <= ARM;
            count_q <= '0;
            sat_q   <= 1'b0;
            vld_q   <= 1'b0;
            width_q <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rsat_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sat_q   <= sat_d;
            vld_q   <= vld_d;
            width_q <= width_d;
            short_q <= short_d;
            long_q  <= long_d;
            rsat_q  <= rsat_d;
            ovr_q   <= ovr_d;
        end
    end

    assign meas_valid = vld_q;
    assign meas_width = width_q;
    assign meas_short = short_q;
    assign meas_long  = long_q;
    assign meas_sat   = rsat_q;
    assign busy       = (state_q == COUNT);
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_monostable_pulse_meter.sv
// Bench for monostable_pulse_meter: scoreboarded results from a default instance plus a CountWidth=8 instance.
module tb_monostable_pulse_meter;

    typedef struct {
        int width;
        bit sh;
        bit lo;
        bit sa;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, q_in, rdy, q8, rdy8;
    logic        vld, shrt, lng, sat, busy, ovr;
    logic [15:0] wid;
    logic        vld8, shrt8, lng8, sat8, busy8, ovr8;
    logic [7:0]  wid8;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    monostable_pulse_meter dut (
        .clk(clk), .reset(reset), .q_in(q_in), .meas_valid(vld), .meas_ready(rdy),
        .meas_width(wid), .meas_short(shrt), .meas_long(lng), .meas_sat(sat),
        .busy(busy), .overrun(ovr)
    );

    monostable_pulse_meter #(.CountWidth(8)) dut8 (
        .clk(clk), .reset(reset), .q_in(q8), .meas_valid(vld8), .meas_ready(rdy8),
        .meas_width(wid8), .meas_short(shrt8), .meas_long(lng8), .meas_sat(sat8),
        .busy(busy8), .overrun(ovr8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input int len);
        exp_t e;
        e.sa    = (len > 65535);
        e.width = e.sa ? 65535 : len;
        e.sh    = (e.width < 80);
        e.lo    = (e.width > 120) || e.sa;
        return e;
    endfunction

    // Drive a pulse of len sampled-high cycles, then watch a fixed tail of low cycles.
    task automatic run_pulse(input int len, output int busy_n, output int vld_n, output int vld_at);
        busy_n = 0;
        vld_n  = 0;
        vld_at = -1;
        q_in   = 1'b1;
        repeat (len) begin
            step();
            if (busy) busy_n++;
        end
        q_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (busy) busy_n++;
            if (vld) vld_n++;
            if (vld && vld_at < 0) vld_at = i;
        end
    endtask

    always @(negedge clk) begin
        if (!reset && vld && rdy) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_width", wid, e.width);
                chk("sb_short", shrt, e.sh);
                chk("sb_long", lng, e.lo);
                chk("sb_sat", sat, e.sa);
            end
        end
    end

    initial begin
        int bn, vn, va, b8;
        reset = 1'b1; q_in = 1'b0; rdy = 1'b0; q8 = 1'b0; rdy8 = 1'b0;
        repeat (3) step();
        chk("reset_outs", {vld, wid, shrt, lng, sat, busy, ovr}, 0);
        chk("reset_outs8", {vld8, wid8, shrt8, lng8, sat8, busy8, ovr8}, 0);
        reset = 1'b0;
        repeat (3) step();

        // 100-cycle pulse, consumer stalled until checked
        exp_q.push_back(model(100));
        run_pulse(100, bn, vn, va);
        chk("p100_busy_cycles", bn, 100);
        chk("p100_vld_latency", va, 3);
        chk("p100_width", wid, 100);
        chk("p100_flags", {vld, shrt, lng, sat}, 4'b1000);
        rdy = 1'b1;
        step();
        chk("p100_vld_clear", vld, 0);

        // short and long pulses with a ready consumer
        exp_q.push_back(model(50));
        run_pulse(50, bn, vn, va);
        chk("p50_vld_once", vn, 1);
        chk("p50_vld_clear", vld, 0);
        exp_q.push_back(model(150));
        run_pulse(150, bn, vn, va);
        chk("p150_vld_once", vn, 1);
        chk("p150_busy_cycles", bn, 150);

        // reset during cycle 40 of a pulse; its remainder must be ignored
        q_in = 1'b1;
        repeat (40) step();
        reset = 1'b1;
        step();
        chk("midreset_outs", {vld, wid, shrt, lng, sat, busy, ovr}, 0);
        reset = 1'b0;
        repeat (60) begin
            step();
            if (busy) chk("midreset_busy", busy, 0);
        end
        q_in = 1'b0;
        repeat (10) step();
        chk("midreset_no_result", vld, 0);
        exp_q.push_back(model(100));
        run_pulse(100, bn, vn, va);
        chk("after_reset_latency", va, 3);

        // overrun: second result dropped while the register is full
        rdy = 1'b0;
        exp_q.push_back(model(100));
        run_pulse(100, bn, vn, va);
        chk("ovr_before", ovr, 0);
        run_pulse(90, bn, vn, va);
        chk("ovr_width_kept", wid, 100);
        chk("ovr_set", ovr, 1);
        chk("ovr_vld", vld, 1);
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("ovr_vld_clear", vld, 0);
        chk("ovr_sticky", ovr, 1);

        // transfer and capture on the same edge
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (2) step();
        exp_q.push_back(model(100));
        run_pulse(100, bn, vn, va);
        exp_q.push_back(model(90));
        q_in = 1'b1;
        repeat (90) step();
        q_in = 1'b0;
        repeat (2) step();
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("same_cycle_vld", vld, 1);
        chk("same_cycle_width", wid, 90);
        chk("same_cycle_ovr", ovr, 0);
        repeat (3) step();
        chk("stable_width", wid, 90);
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("same_cycle_drain", vld, 0);

        // saturation on the 8-bit instance
        b8 = 0;
        q8 = 1'b1;
        repeat (300) begin
            step();
            if (busy8) b8++;
        end
        chk("sat8_busy_before_fall", busy8, 1);
        q8 = 1'b0;
        repeat (8) begin
            step();
            if (busy8) b8++;
        end
        chk("sat8_busy_cycles", b8, 300);
        chk("sat8_width", wid8, 255);
        chk("sat8_flags", {vld8, shrt8, lng8, sat8}, 4'b1011);

        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
